test_sequencer: RTL and testbench



---
 rtl/test_sequencer.sv | 157 +++++++++++++++
 tb/tb_test_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// Queued test-parameter sequencer feeding control_block: walks a table of param words
// for a number of passes, with abort, stop-on-error and pass/fail statistics.
module test_sequencer #(
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cfg_wr_i,
  input  logic [31:0]                      cfg_data_i,
  input  logic                             cfg_clear_i,
  input  logic                             seq_start_i,
  input  logic                             seq_abort_i,
  input  logic [CNT_W-1:0]                 seq_loops_i,
  input  logic                             stop_on_err_i,
  output logic                             test_start_o,
  output logic [31:0]                      test_param_o,
  input  logic                             test_finished_i,
  input  logic                             test_result_i,
  output logic                             seq_busy_o,
  output logic                             seq_done_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_cnt_o,
  output logic                             queue_full_o,
  output logic                             cfg_err_o,
  output logic [CNT_W-1:0]                 pass_cnt_o,
  output logic [CNT_W-1:0]                 fail_cnt_o,
  output logic                             first_fail_vld_o,
  output logic [$clog2(QUEUE_DEPTH)-1:0]   first_fail_idx_o
);
  localparam int unsigned QW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned IW = $clog2(QUEUE_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ARM, S_WAIT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      mem [QUEUE_DEPTH];
  logic [IW-1:0]    rd_idx, rd_nxt;
  logic [CNT_W-1:0] loops, loops_nxt;
  logic             abort_pend;
  logic             is_idle, clear_acc, wr_acc, wr_err, start_ok, start_err, last, fin;

  assign is_idle      = (state == S_IDLE);
  assign queue_full_o = (queue_cnt_o == QW'(QUEUE_DEPTH));
  assign clear_acc    = is_idle & cfg_clear_i;
  assign wr_acc       = is_idle & cfg_wr_i & ~cfg_clear_i & ~queue_full_o;
  assign wr_err       = cfg_wr_i & ~clear_acc & (~is_idle | queue_full_o);
  assign start_ok     = is_idle & seq_start_i & ~seq_abort_i & ~cfg_clear_i & (queue_cnt_o != '0);
  assign start_err    = is_idle & seq_start_i & (queue_cnt_o == '0);
  assign last         = (QW'(rd_idx) == queue_cnt_o - QW'(1));
  assign fin          = (state == S_WAIT) & test_finished_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rd_nxt       = rd_idx;
    loops_nxt    = loops;
    test_start_o = 1'b0;
    seq_busy_o   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = S_LAUNCH;
          rd_nxt    = '0;
          loops_nxt = (seq_loops_i == '0) ? CNT_W'(1) : seq_loops_i;
        end
      end
      S_LAUNCH: begin
        test_start_o = 1'b1;
        seq_busy_o   = 1'b1;
        state_nxt    = S_ARM;
      end
      S_ARM: begin
        seq_busy_o = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        seq_busy_o = 1'b1;
        if (test_finished_i) begin
          // an abort arriving on the finishing edge is honoured immediately
          if (abort_pend || seq_abort_i)            state_nxt = S_DONE;
          else if (test_result_i && stop_on_err_i)  state_nxt = S_DONE;
          else if (last) begin
            if (loops == CNT_W'(1)) state_nxt = S_DONE;
            else begin
              loops_nxt = loops - CNT_W'(1);
              rd_nxt    = '0;
              state_nxt = S_LAUNCH;
            end
          end else begin
            rd_nxt    = rd_idx + 1'b1;
            state_nxt = S_LAUNCH;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[queue_cnt_o[IW-1:0]] <= cfg_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_idx           <= '0;
      loops            <= '0;
      abort_pend       <= 1'b0;
      test_param_o     <= '0;
      seq_done_o       <= 1'b0;
      queue_cnt_o      <= '0;
      cfg_err_o        <= 1'b0;
      pass_cnt_o       <= '0;
      fail_cnt_o       <= '0;
      first_fail_vld_o <= 1'b0;
      first_fail_idx_o <= '0;
    end else begin
      rd_idx <= rd_nxt;
      loops  <= loops_nxt;
      // param is loaded on entry to LAUNCH so it is already valid alongside the start strobe
      if (state_nxt == S_LAUNCH) test_param_o <= mem[rd_nxt];

      if (clear_acc)   queue_cnt_o <= '0;
      else if (wr_acc) queue_cnt_o <= queue_cnt_o + QW'(1);

      if (wr_err || start_err) cfg_err_o <= 1'b1;
      else if (clear_acc)      cfg_err_o <= 1'b0;

      if (state_nxt == S_DONE || start_ok) abort_pend <= 1'b0;
      else if (seq_abort_i && seq_busy_o)  abort_pend <= 1'b1;

      if (start_ok)                 seq_done_o <= 1'b0;
      else if (state_nxt == S_DONE) seq_done_o <= 1'b1;

      if (start_ok) begin
        pass_cnt_o       <= '0;
        fail_cnt_o       <= '0;
        first_fail_vld_o <= 1'b0;
        first_fail_idx_o <= '0;
      end else if (fin) begin
        if (test_result_i) begin
          if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + CNT_W'(1);
          if (!first_fail_vld_o) begin
            first_fail_vld_o <= 1'b1;
            first_fail_idx_o <= rd_idx;
          end
        end else if (pass_cnt_o != '1) begin
          pass_cnt_o <= pass_cnt_o + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: table-driven queue config vectors, directed and random
// sequences checked against a list-walking model, with a control_block responder.
module tb_test_sequencer;
  localparam int QD = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_wr = 1'b0, cfg_clear = 1'b0, seq_start = 1'b0, seq_abort = 1'b0;
  logic [31:0]   cfg_data = '0;
  logic [CW-1:0] seq_loops = '0;
  logic          stop_on_err = 1'b0;
  logic          test_start, test_finished, test_result;
  logic [31:0]   test_param;
  logic          seq_busy, seq_done, queue_full, cfg_err, ff_vld;
  logic [3:0]    queue_cnt;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic [2:0]    ff_idx;

  test_sequencer #(.QUEUE_DEPTH(QD), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_wr_i(cfg_wr), .cfg_data_i(cfg_data),
    .cfg_clear_i(cfg_clear), .seq_start_i(seq_start), .seq_abort_i(seq_abort),
    .seq_loops_i(seq_loops), .stop_on_err_i(stop_on_err), .test_start_o(test_start),
    .test_param_o(test_param), .test_finished_i(test_finished), .test_result_i(test_result),
    .seq_busy_o(seq_busy), .seq_done_o(seq_done), .queue_cnt_o(queue_cnt),
    .queue_full_o(queue_full), .cfg_err_o(cfg_err), .pass_cnt_o(pass_cnt),
    .fail_cnt_o(fail_cnt), .first_fail_vld_o(ff_vld), .first_fail_idx_o(ff_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // control_block responder: fail when param bit 0 is set; finish stays high (stale) after a test
  int          dur_max = 2;
  int          long_dur = 0;
  int          abort_at = 0;
  int          start_no = 0;
  logic [31:0] got[$];
  bit          nxt_seen[$];

  initial begin
    bit pending;
    int d;
    test_finished = 1'b0;
    test_result   = 1'b0;
    pending       = 1'b0;
    forever begin
      if (!pending) @(negedge clk);
      pending = 1'b0;
      if (test_start === 1'b1) begin
        start_no++;
        @(negedge clk);
        chk("start_pulse_width", {31'b0, test_start}, 32'd0);
        got.push_back(test_param);
        if (start_no == abort_at) seq_abort = 1'b1;
        @(negedge clk);
        seq_abort = 1'b0;
        chk("param_stable", test_param, got[$]);
        test_finished = 1'b0;
        d = (long_dur != 0) ? long_dur : $urandom_range(0, dur_max);
        repeat (d) @(negedge clk);
        test_result   = got[$][0];
        test_finished = 1'b1;
        @(negedge clk);
        nxt_seen.push_back(test_start);
        pending = 1'b1;
      end
    end
  end

  logic [31:0] qm[$];
  logic [31:0] exp_p[$];
  int          e_pass, e_fail, e_ffi;
  bit          e_ffv;

  // Reference: walk the table pass by pass, stopping per abort / stop-on-error rules
  task automatic model(input int loops, input bit soe, input int ab);
    int  n, lp, maxc;
    bit  stop, f;
    exp_p.delete();
    e_pass = 0; e_fail = 0; e_ffv = 0; e_ffi = 0; n = 0; stop = 0;
    maxc = (1 << CW) - 1;
    lp = (loops == 0) ? 1 : loops;
    for (int p = 0; p < lp && !stop; p++)
      for (int i = 0; i < qm.size() && !stop; i++) begin
        exp_p.push_back(qm[i]);
        n++;
        f = qm[i][0];
        if (f) begin
          if (e_fail < maxc) e_fail++;
          if (!e_ffv) begin e_ffv = 1; e_ffi = i; end
        end else if (e_pass < maxc) e_pass++;
        if (n == ab) stop = 1;
        else if (f && soe) stop = 1;
      end
  endtask

  task automatic wr_word(input logic [31:0] w);
    cfg_wr = 1'b1; cfg_data = w;
    @(negedge clk);
    cfg_wr = 1'b0;
    if (qm.size() < QD) qm.push_back(w);
  endtask

  task automatic do_clear();
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    qm.delete();
  endtask

  task automatic run_seq(input int loops, input bit soe, input int ab, input bit poke);
    int cyc;
    int qc;
    model(loops, soe, ab);
    got.delete(); nxt_seen.delete(); start_no = 0; abort_at = ab;
    qc = qm.size();
    seq_loops = CW'(loops); stop_on_err = soe; seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
    chk("busy_after_start", {31'b0, seq_busy}, 32'd1);
    chk("done_cleared", {31'b0, seq_done}, 32'd0);
    if (poke) begin
      @(negedge clk);
      cfg_wr = 1'b1; cfg_data = 32'hDEAD_0000;
      @(negedge clk);
      cfg_wr = 1'b0; cfg_clear = 1'b1;
      @(negedge clk);
      cfg_clear = 1'b0; seq_start = 1'b1;
      @(negedge clk);
      seq_start = 1'b0;
    end
    cyc = 0;
    while (seq_done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_within_budget", {31'b0, seq_done}, 32'd1);
    repeat (2) @(negedge clk);
    chk("busy_after_done", {31'b0, seq_busy}, 32'd0);
    chk("done_sticky", {31'b0, seq_done}, 32'd1);
    chk("num_starts", got.size(), exp_p.size());
    for (int i = 0; i < got.size() && i < exp_p.size(); i++) chk("param_order", got[i], exp_p[i]);
    for (int i = 0; i < nxt_seen.size(); i++)
      chk("b2b_restart", {31'b0, nxt_seen[i]}, (i < exp_p.size() - 1) ? 32'd1 : 32'd0);
    chk("pass_cnt", pass_cnt, e_pass);
    chk("fail_cnt", fail_cnt, e_fail);
    chk("ff_vld", {31'b0, ff_vld}, {31'b0, e_ffv});
    if (e_ffv) chk("ff_idx", ff_idx, e_ffi);
    if (poke) begin
      chk("busy_wr_err", {31'b0, cfg_err}, 32'd1);
      chk("busy_queue_kept", queue_cnt, qc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, {31'b0, test_start}, 0);
    chk({tag, "_param"}, test_param, 0);
    chk({tag, "_busy"}, {31'b0, seq_busy}, 0);
    chk({tag, "_done"}, {31'b0, seq_done}, 0);
    chk({tag, "_qcnt"}, queue_cnt, 0);
    chk({tag, "_full"}, {31'b0, queue_full}, 0);
    chk({tag, "_err"}, {31'b0, cfg_err}, 0);
    chk({tag, "_pass"}, pass_cnt, 0);
    chk({tag, "_fail"}, fail_cnt, 0);
    chk({tag, "_ffv"}, {31'b0, ff_vld}, 0);
    chk({tag, "_ffi"}, ff_idx, 0);
  endtask

  typedef struct {
    bit          wr;
    bit          clr;
    logic [31:0] data;
    int          cnt;
    bit          full;
    bit          err;
  } vec_t;
  vec_t vt[14];

  initial begin
    int n, lp, ab;
    bit soe;

    #2 rst = 1'b1;
    #2 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      vt[i] = '{wr: 1, clr: 0, data: 32'h1000 + 32'(i * 2), cnt: (i < 8) ? i + 1 : 8,
                full: (i >= 7), err: (i == 8)};
    vt[9]  = '{wr: 0, clr: 1, data: 0, cnt: 0, full: 0, err: 0};
    vt[10] = '{wr: 1, clr: 1, data: 32'h55, cnt: 0, full: 0, err: 0};
    vt[11] = '{wr: 1, clr: 0, data: 32'h66, cnt: 1, full: 0, err: 0};
    vt[12] = '{wr: 1, clr: 0, data: 32'h77, cnt: 2, full: 0, err: 0};
    vt[13] = '{wr: 0, clr: 1, data: 0, cnt: 0, full: 0, err: 0};
    for (int i = 0; i < 14; i++) begin
      cfg_wr = vt[i].wr; cfg_clear = vt[i].clr; cfg_data = vt[i].data;
      @(negedge clk);
      cfg_wr = 1'b0; cfg_clear = 1'b0;
      chk("tbl_qcnt", queue_cnt, vt[i].cnt);
      chk("tbl_full", {31'b0, queue_full}, {31'b0, vt[i].full});
      chk("tbl_err", {31'b0, cfg_err}, {31'b0, vt[i].err});
    end
    qm.delete();

    start_no = 0; seq_loops = 1; seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("empty_start_no_launch", start_no, 0);
    chk("empty_start_err", {31'b0, cfg_err}, 32'd1);
    chk("empty_start_idle", {31'b0, seq_busy}, 32'd0);
    do_clear();
    chk("err_cleared", {31'b0, cfg_err}, 32'd0);

    wr_word(32'hA000_0010); wr_word(32'hA000_0020); wr_word(32'hA000_0030);
    run_seq(1, 0, 0, 0);
    do_clear();
    wr_word(32'hB000_0100); wr_word(32'hB000_0201);
    run_seq(3, 0, 0, 0);
    run_seq(3, 1, 0, 0);
    run_seq(0, 0, 0, 0);
    do_clear();
    for (int i = 0; i < 4; i++) wr_word(32'hC000_0000 + 32'(i << 4));
    run_seq(1, 0, 1, 0);
    do_clear();
    for (int i = 0; i < 8; i++) wr_word(32'hD000_0000 + 32'(i << 4));
    run_seq(3, 0, 0, 0);

    long_dur = 10;
    run_seq(1, 0, 0, 1);
    long_dur = 0;
    do_clear();

    for (int r = 0; r < 12; r++) begin
      do_clear();
      n = $urandom_range(1, QD);
      for (int i = 0; i < n; i++)
        wr_word({$urandom_range(0, 32'h7FFF_FFFF), 1'b0} | (($urandom_range(0, 2) == 0) ? 32'd1 : 32'd0));
      lp  = $urandom_range(0, 3);
      soe = $urandom_range(0, 1);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      dur_max = $urandom_range(0, 3);
      run_seq(lp, soe, ab, 0);
    end

    do_clear();
    wr_word(32'hE000_0010); wr_word(32'hE000_0020);
    long_dur = 40;
    seq_loops = 1; stop_on_err = 0; seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_reset", {31'b0, seq_busy}, 32'd1);
    rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_after_reset", {31'b0, seq_busy}, 32'd0);
    chk("no_start_after_reset", {31'b0, test_start}, 32'd0);
    long_dur = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
